// File: rtl/aklc_pkg.sv
// Shared definitions for the multi-slot alarm clock.
//   alarm_state_e  : alarm FSM states
//   *_LSB          : bit offsets of the four BCD digits in a packed time word
//                    {ms_hr, ls_hr, ms_min, ls_min}
//   bcd_time_valid : true when a packed word is a legal 24-hour time 00:00..23:59
package aklc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } alarm_state_e;

   localparam int LS_MIN_LSB = 0;
   localparam int MS_MIN_LSB = 4;
   localparam int LS_HR_LSB  = 8;
   localparam int MS_HR_LSB  = 12;

   function automatic logic bcd_time_valid(input logic [15:0] t);
      logic [3:0] mh;
      logic [3:0] lh;
      logic [3:0] mm;
      logic [3:0] lm;
      mh = t[MS_HR_LSB +: 4];
      lh = t[LS_HR_LSB +: 4];
      mm = t[MS_MIN_LSB +: 4];
      lm = t[LS_MIN_LSB +: 4];
      // Hours 20..23 only allow a units digit up to 3; tens of minutes up to 5.
      return (lm <= 4'd9) && (mm <= 4'd5) && (lh <= 4'd9) &&
             ((mh < 4'd2) || ((mh == 4'd2) && (lh <= 4'd3)));
   endfunction

endpackage

// File: rtl/aklc_bcd_time_cnt.sv
// BCD 24-hour time-of-day counter.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i (ignored when not a legal time)
//   load_val_i   : packed BCD time to load
//   tick_i       : one-cycle minute tick, advances the time by one minute
//   time_o       : current packed BCD time
//   eval_o       : high for the one cycle after a tick actually advanced time
module aklc_bcd_time_cnt
   import aklc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   input  logic        tick_i,
   output logic [15:0] time_o,
   output logic        eval_o
);

   logic [15:0] time_q, time_d;
   logic        eval_q, eval_d;
   logic        load_ok;
   logic [3:0]  mh, lh, mm, lm;
   logic [3:0]  mh_n, lh_n, mm_n, lm_n;

   assign mh = time_q[MS_HR_LSB +: 4];
   assign lh = time_q[LS_HR_LSB +: 4];
   assign mm = time_q[MS_MIN_LSB +: 4];
   assign lm = time_q[LS_MIN_LSB +: 4];

   // One-minute increment with digit carries; 23:59 rolls to 00:00.
   always_comb begin
      mh_n = mh;
      lh_n = lh;
      mm_n = mm;
      lm_n = lm;
      if (lm != 4'd9) begin
         lm_n = lm + 4'd1;
      end else begin
         lm_n = 4'd0;
         if (mm != 4'd5) begin
            mm_n = mm + 4'd1;
         end else begin
            mm_n = 4'd0;
            if ((mh == 4'd2) && (lh == 4'd3)) begin
               mh_n = 4'd0;
               lh_n = 4'd0;
            end else if (lh == 4'd9) begin
               lh_n = 4'd0;
               mh_n = mh + 4'd1;
            end else begin
               lh_n = lh + 4'd1;
            end
         end
      end
   end

   // A legal load wins over a tick; an illegal load is treated as absent.
   always_comb begin
      load_ok = load_i && bcd_time_valid(load_val_i);
      time_d  = time_q;
      eval_d  = 1'b0;
      if (load_ok) begin
         time_d = load_val_i;
      end else if (tick_i) begin
         time_d = {mh_n, lh_n, mm_n, lm_n};
         eval_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_q <= 16'h0000;
         eval_q <= 1'b0;
      end else begin
         time_q <= time_d;
         eval_q <= eval_d;
      end
   end

   assign time_o = time_q;
   assign eval_o = eval_q;

endmodule

// File: rtl/aklc_multi_alarm.sv
// Multi-slot alarm clock with snooze and ring auto-stop.
//   clk, rst     : clock, asynchronous active-high reset
//   one_minute   : one-cycle minute tick
//   load_time    : load time_in (legal times only)
//   time_in      : packed BCD time {ms_hr, ls_hr, ms_min, ls_min}
//   load_alarm   : write alarm_in into slot alarm_sel (legal slot and time only)
//   alarm_sel    : slot index
//   alarm_in     : packed BCD alarm time
//   alarm_en     : per-slot enable
//   snooze, stop : one-cycle user requests
//   cur_time     : current packed BCD time
//   sound_alarm  : high while ringing
//   snoozing     : high while snoozed
//   active_slot  : slot owning the current ring/snooze, 0 when idle
module aklc_multi_alarm
   import aklc_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  one_minute,
   input  logic                  load_time,
   input  logic [15:0]           time_in,
   input  logic                  load_alarm,
   input  logic [3:0]            alarm_sel,
   input  logic [15:0]           alarm_in,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   input  logic                  snooze,
   input  logic                  stop,
   output logic [15:0]           cur_time,
   output logic                  sound_alarm,
   output logic                  snoozing,
   output logic [3:0]            active_slot
);

   localparam logic [3:0] RING_RELOAD   = 4'(RING_MIN);
   localparam logic [3:0] SNOOZE_RELOAD = 4'(SNOOZE_MIN);

   logic                  eval_q;
   logic                  alarm_wr;
   logic [NUM_ALARMS-1:0] match_vec;
   logic                  match_any;
   logic [3:0]            match_idx;
   logic [15:0]           en_ext;
   logic                  slot_en;

   alarm_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   active_q, active_d;

   aklc_bcd_time_cnt u_time (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_time),
      .load_val_i (time_in),
      .tick_i     (one_minute),
      .time_o     (cur_time),
      .eval_o     (eval_q)
   );

   // Out-of-range slot indices must not alias onto a real slot.
   assign alarm_wr = load_alarm && ({1'b0, alarm_sel} < 5'(NUM_ALARMS)) &&
                     bcd_time_valid(alarm_in);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
         logic [15:0] slot_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_q <= 16'h0000;
            end else if (alarm_wr && (alarm_sel == 4'(gi))) begin
               slot_q <= alarm_in;
            end
         end
         assign match_vec[gi] = alarm_en[gi] && (slot_q == cur_time);
      end
   endgenerate

   // Priority encode: scanning downwards leaves the lowest matching index.
   always_comb begin
      match_any = 1'b0;
      match_idx = 4'd0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (match_vec[i]) begin
            match_any = 1'b1;
            match_idx = 4'(i);
         end
      end
   end

   // Zero-extend so the owning slot can be indexed with the full 4-bit value.
   assign en_ext  = 16'(alarm_en);
   assign slot_en = en_ext[active_q];

   // cnt_q counts remaining minute ticks: ring timeout while RINGING,
   // snooze length while SNOOZE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      case (state_q)
         ST_IDLE: begin
            if (eval_q && match_any) begin
               state_d  = ST_RINGING;
               cnt_d    = RING_RELOAD;
               active_d = match_idx;
            end
         end
         ST_RINGING: begin
            if (stop || !slot_en) begin
               state_d  = ST_IDLE;
               cnt_d    = 4'd0;
               active_d = 4'd0;
            end else if (snooze) begin
               state_d = ST_SNOOZE;
               cnt_d   = SNOOZE_RELOAD;
            end else if (one_minute) begin
               if (cnt_q == 4'd1) begin
                  state_d  = ST_IDLE;
                  cnt_d    = 4'd0;
                  active_d = 4'd0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         ST_SNOOZE: begin
            if (stop || !slot_en) begin
               state_d  = ST_IDLE;
               cnt_d    = 4'd0;
               active_d = 4'd0;
            end else if (one_minute) begin
               if (cnt_q == 4'd1) begin
                  state_d = ST_RINGING;
                  cnt_d   = RING_RELOAD;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            active_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         active_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign sound_alarm = (state_q == ST_RINGING);
   assign snoozing    = (state_q == ST_SNOOZE);
   assign active_slot = active_q;

endmodule
